// File: rtl/responder_judge.sv
// Quiz answer arbiter: first-press detection with a per-question countdown.
// It also flags foul presses and timeouts, and drives the winner LED and a timed buzzer pulse.
module responder_judge #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned WINDOW      = 10,
  parameter int unsigned BEEP_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_flag,
  input  logic       start_flag,
  input  logic       clear_flag,
  output logic [3:0] led,
  output logic       foul,
  output logic       timeout,
  output logic [3:0] remain,
  output logic       beep
);

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned BeepW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [TickW-1:0] TickLast   = TickW'(TICK_CYCLES - 1);
  localparam logic [BeepW-1:0] BeepLast   = BeepW'(BEEP_CYCLES - 1);
  localparam logic [3:0]       RemainInit = 4'(WINDOW);

  typedef enum logic [2:0] {StIdle, StArmed, StLocked, StFoul, StTimeout} state_e;

  state_e           state;
  logic [TickW-1:0] tick_cnt;
  logic [BeepW-1:0] beep_cnt;
  logic [3:0]       key_first;
  logic             key_any;
  logic             tick_wrap;

  // Two's-complement trick isolates the lowest set bit, giving bit 0 top priority.
  assign key_first = key_flag & (~key_flag + 4'd1);
  assign key_any   = |key_flag;
  assign tick_wrap = (tick_cnt == TickLast);

  always_ff @(posedge clk) begin
    if (!rst_n || clear_flag) begin
      state    <= StIdle;
      tick_cnt <= '0;
      beep_cnt <= '0;
      led      <= 4'b0000;
      foul     <= 1'b0;
      timeout  <= 1'b0;
      remain   <= RemainInit;
      beep     <= 1'b0;
    end else begin
      // Beep only ever starts on entry to a terminal state, so this never
      // collides with the entry assignments below.
      if (beep) begin
        if (beep_cnt == BeepLast) begin
          beep     <= 1'b0;
          beep_cnt <= '0;
        end else begin
          beep_cnt <= beep_cnt + 1'b1;
        end
      end

      case (state)
        StIdle: begin
          if (key_any) begin
            state    <= StFoul;
            led      <= key_first;
            foul     <= 1'b1;
            beep     <= 1'b1;
            beep_cnt <= '0;
          end else if (start_flag) begin
            state    <= StArmed;
            tick_cnt <= '0;
          end
        end

        StArmed: begin
          if (key_any) begin
            state    <= StLocked;
            led      <= key_first;
            beep     <= 1'b1;
            beep_cnt <= '0;
          end else if (tick_wrap) begin
            tick_cnt <= '0;
            if (remain <= 4'd1) begin
              state    <= StTimeout;
              remain   <= 4'd0;
              timeout  <= 1'b1;
              beep     <= 1'b1;
              beep_cnt <= '0;
            end else begin
              remain <= remain - 4'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          // Terminal states hold everything until clear or reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_responder_judge.sv
// Scoreboard bench for responder_judge: per-cycle expected outputs are queued
// alongside stimulus and compared one cycle after each drive.
module tb_responder_judge;

  localparam int unsigned TICK = 10;
  localparam int unsigned WIN  = 3;
  localparam int unsigned BEEP = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_flag = 4'b0000;
  logic       start_flag = 1'b0;
  logic       clear_flag = 1'b0;
  logic [3:0] led;
  logic       foul;
  logic       timeout;
  logic [3:0] remain;
  logic       beep;

  always #10 clk = ~clk;

  responder_judge #(
    .TICK_CYCLES(TICK),
    .WINDOW     (WIN),
    .BEEP_CYCLES(BEEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_flag  (key_flag),
    .start_flag(start_flag),
    .clear_flag(clear_flag),
    .led       (led),
    .foul      (foul),
    .timeout   (timeout),
    .remain    (remain),
    .beep      (beep)
  );

  int tests = 0;
  int fails = 0;

  // stim: {rst_n, clear, start, key[3:0]}; expected: {led, foul, timeout, remain, beep}
  logic [6:0]  stim_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] obs;
  assign obs = {led, foul, timeout, remain, beep};

  localparam logic [6:0]  NOP    = 7'b1_0_0_0000;
  localparam logic [6:0]  START  = 7'b1_0_1_0000;
  localparam logic [6:0]  CLEAR  = 7'b1_1_0_0000;
  localparam logic [6:0]  RST    = 7'b0_0_0_0000;
  localparam logic [10:0] IDLE_O = {4'b0000, 1'b0, 1'b0, 4'd3, 1'b0};

  function automatic logic [6:0] key(input logic [3:0] k, input logic s);
    return {1'b1, 1'b0, s, k};
  endfunction

  function automatic logic [10:0] ex(input logic [3:0] l, input logic f, input logic t,
                                     input logic [3:0] r, input logic b);
    return {l, f, t, r, b};
  endfunction

  task automatic push(input logic [6:0] s, input logic [10:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [10:0] e;
    int n = 0;
    for (int i = 0; i < 5; i++) push(RST, IDLE_O);
    for (int i = 0; i < 6; i++) push(NOP, IDLE_O);
    while (stim_q.size() > 0) begin
      {rst_n, clear_flag, start_flag, key_flag} = stim_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      n++;
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset[%0d]: got led=%b foul=%b to=%b remain=%0d beep=%b, want led=%b foul=%b to=%b remain=%0d beep=%b",
                 n, led, foul, timeout, remain, beep, e[10:7], e[6], e[5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_valid_answer();
    logic [10:0] e;
    int n = 0;
    push(START, IDLE_O);
    for (int k = 1; k <= 11; k++) push(NOP, ex(4'b0000, 1'b0, 1'b0, 4'(3 - k / 10), 1'b0));
    push(key(4'b0100, 1'b0), ex(4'b0100, 1'b0, 1'b0, 4'd2, 1'b1));
    push(NOP,                ex(4'b0100, 1'b0, 1'b0, 4'd2, 1'b1));
    push(key(4'b0001, 1'b0), ex(4'b0100, 1'b0, 1'b0, 4'd2, 1'b1));
    push(START,              ex(4'b0100, 1'b0, 1'b0, 4'd2, 1'b1));
    push(NOP,                ex(4'b0100, 1'b0, 1'b0, 4'd2, 1'b1));
    for (int k = 17; k <= 22; k++) push(NOP, ex(4'b0100, 1'b0, 1'b0, 4'd2, 1'b0));
    push(CLEAR, IDLE_O);
    while (stim_q.size() > 0) begin
      {rst_n, clear_flag, start_flag, key_flag} = stim_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      n++;
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL valid[%0d]: got led=%b foul=%b to=%b remain=%0d beep=%b, want led=%b foul=%b to=%b remain=%0d beep=%b",
                 n, led, foul, timeout, remain, beep, e[10:7], e[6], e[5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [10:0] e;
    int n = 0;
    push(START, IDLE_O);
    for (int k = 1; k <= 3; k++) push(NOP, IDLE_O);
    push(key(4'b0110, 1'b0), ex(4'b0010, 1'b0, 1'b0, 4'd3, 1'b1));
    push(CLEAR, IDLE_O);
    push(key(4'b1100, 1'b0), ex(4'b0100, 1'b1, 1'b0, 4'd3, 1'b1));
    push(CLEAR, IDLE_O);
    push(key(4'b1111, 1'b1), ex(4'b0001, 1'b1, 1'b0, 4'd3, 1'b1));
    push(CLEAR, IDLE_O);
    while (stim_q.size() > 0) begin
      {rst_n, clear_flag, start_flag, key_flag} = stim_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      n++;
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL simul[%0d]: got led=%b foul=%b to=%b remain=%0d beep=%b, want led=%b foul=%b to=%b remain=%0d beep=%b",
                 n, led, foul, timeout, remain, beep, e[10:7], e[6], e[5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_foul();
    logic [10:0] e;
    int n = 0;
    push(key(4'b1000, 1'b0), ex(4'b1000, 1'b1, 1'b0, 4'd3, 1'b1));
    push(START, ex(4'b1000, 1'b1, 1'b0, 4'd3, 1'b1));
    for (int k = 2; k <= 4; k++) push(NOP, ex(4'b1000, 1'b1, 1'b0, 4'd3, 1'b1));
    push(START, ex(4'b1000, 1'b1, 1'b0, 4'd3, 1'b0));
    for (int k = 6; k <= 14; k++) push(NOP, ex(4'b1000, 1'b1, 1'b0, 4'd3, 1'b0));
    push(CLEAR, IDLE_O);
    push(key(4'b0001, 1'b0), ex(4'b0001, 1'b1, 1'b0, 4'd3, 1'b1));
    push(CLEAR, IDLE_O);
    while (stim_q.size() > 0) begin
      {rst_n, clear_flag, start_flag, key_flag} = stim_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      n++;
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL foul[%0d]: got led=%b foul=%b to=%b remain=%0d beep=%b, want led=%b foul=%b to=%b remain=%0d beep=%b",
                 n, led, foul, timeout, remain, beep, e[10:7], e[6], e[5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] e;
    int n = 0;
    push(START, IDLE_O);
    for (int k = 1; k <= 29; k++) push(NOP, ex(4'b0000, 1'b0, 1'b0, 4'(3 - k / 10), 1'b0));
    push(NOP, ex(4'b0000, 1'b0, 1'b1, 4'd0, 1'b1));
    push(NOP, ex(4'b0000, 1'b0, 1'b1, 4'd0, 1'b1));
    push(key(4'b0010, 1'b1), ex(4'b0000, 1'b0, 1'b1, 4'd0, 1'b1));
    push(NOP, ex(4'b0000, 1'b0, 1'b1, 4'd0, 1'b1));
    push(NOP, ex(4'b0000, 1'b0, 1'b1, 4'd0, 1'b1));
    for (int k = 35; k <= 37; k++) push(NOP, ex(4'b0000, 1'b0, 1'b1, 4'd0, 1'b0));
    push(CLEAR, IDLE_O);
    // key arriving on the final tick edge wins over the timeout
    push(START, IDLE_O);
    for (int k = 1; k <= 29; k++) push(NOP, ex(4'b0000, 1'b0, 1'b0, 4'(3 - k / 10), 1'b0));
    push(key(4'b0010, 1'b0), ex(4'b0010, 1'b0, 1'b0, 4'd1, 1'b1));
    for (int k = 31; k <= 34; k++) push(NOP, ex(4'b0010, 1'b0, 1'b0, 4'd1, 1'b1));
    push(NOP, ex(4'b0010, 1'b0, 1'b0, 4'd1, 1'b0));
    push(CLEAR, IDLE_O);
    while (stim_q.size() > 0) begin
      {rst_n, clear_flag, start_flag, key_flag} = stim_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      n++;
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL timeout[%0d]: got led=%b foul=%b to=%b remain=%0d beep=%b, want led=%b foul=%b to=%b remain=%0d beep=%b",
                 n, led, foul, timeout, remain, beep, e[10:7], e[6], e[5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_abort();
    logic [10:0] e;
    int n = 0;
    push(START, IDLE_O);
    push(NOP, IDLE_O);
    push(key(4'b0001, 1'b0), ex(4'b0001, 1'b0, 1'b0, 4'd3, 1'b1));
    push(NOP, ex(4'b0001, 1'b0, 1'b0, 4'd3, 1'b1));
    push(CLEAR, IDLE_O);
    for (int k = 0; k < 5; k++) push(NOP, IDLE_O);
    push(START, IDLE_O);
    for (int k = 1; k <= 14; k++) push(NOP, ex(4'b0000, 1'b0, 1'b0, 4'(3 - k / 10), 1'b0));
    push(RST, IDLE_O);
    for (int k = 0; k < 12; k++) push(NOP, IDLE_O);
    push(key(4'b0100, 1'b0), ex(4'b0100, 1'b1, 1'b0, 4'd3, 1'b1));
    push(NOP, ex(4'b0100, 1'b1, 1'b0, 4'd3, 1'b1));
    push(RST, IDLE_O);
    for (int k = 0; k < 6; k++) push(NOP, IDLE_O);
    while (stim_q.size() > 0) begin
      {rst_n, clear_flag, start_flag, key_flag} = stim_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      n++;
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL abort[%0d]: got led=%b foul=%b to=%b remain=%0d beep=%b, want led=%b foul=%b to=%b remain=%0d beep=%b",
                 n, led, foul, timeout, remain, beep, e[10:7], e[6], e[5], e[4:1], e[0]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_answer();
    test_simultaneous();
    test_foul();
    test_timeout();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/responder_judge.md
# responder_judge

Answer-arbitration core of the quiz responder. It consumes the debounced, one-cycle press pulses produced by the four-key filter stage and decides who answered first. It also runs a per-question countdown window, flags early (foul) presses and timeouts, and drives the winner LED and a timed buzzer pulse. It sits between the key filter bank and the display/buzzer drivers.

## Interface
Parameters:
- TICK_CYCLES, 50_000_000: clock cycles per countdown second (1 s at 50 MHz).
- WINDOW, 10: answer window length in seconds. Legal range 1..15.
- BEEP_CYCLES, 10_000_000: buzzer pulse length in cycles (200 ms at 50 MHz).

Ports:
- clk, in, 1: system clock. All logic is on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- key_flag, in, 4: debounced press pulses, each one cycle wide. Bit i is contestant i.
- start_flag, in, 1: host "start question" pulse, one cycle wide.
- clear_flag, in, 1: host "clear/next question" pulse, one cycle wide.
- led, out, 4: one-hot, active-high indicator of the winner or the fouling contestant.
- foul, out, 1: high while in FOUL.
- timeout, out, 1: high while in TIMEOUT.
- remain, out, 4: seconds remaining in the window, unsigned.
- beep, out, 1: buzzer enable.

## Operation
- States: IDLE, ARMED, LOCKED, FOUL, TIMEOUT. The state is encoded in registers.
- Priority order, highest first: rst_n low, then clear_flag, then key_flag, then the countdown tick, then start_flag.
- Lowest-index rule: when several key_flag bits are set in the same cycle, the lowest set bit index wins (bit 0 has highest priority). led takes that single bit.
- IDLE behaviour:
  - Outputs: led=0, remain=WINDOW, foul=0, timeout=0.
  - key_flag≠0 moves to FOUL and latches led. This includes a key_flag in the same cycle as start_flag.
  - Otherwise start_flag moves to ARMED, with the tick counter cleared.
- ARMED behaviour:
  - A tick counter counts 0..TICK_CYCLES-1. When it wraps, remain decrements by 1.
  - If a decrement would take remain from 1 to 0, the state moves to TIMEOUT with remain=0.
  - key_flag≠0 moves to LOCKED and latches led. remain freezes at its current value.
  - If a key_flag and the final tick occur in the same cycle, the key wins: LOCKED, remain=1.
  - start_flag is ignored.
- LOCKED, FOUL and TIMEOUT are terminal:
  - key_flag and start_flag are ignored.
  - led, remain, foul and timeout hold their values.
  - Only clear_flag or reset leaves these states.
- clear_flag behaviour:
  - Any state returns to IDLE.
  - The tick counter and beep counter clear, and beep drops.
  - All outputs return to their IDLE values.
- beep behaviour:
  - On entry to LOCKED, FOUL or TIMEOUT, beep is high for exactly BEEP_CYCLES consecutive cycles, then low.
  - The beep is cut short only by clear_flag or reset.
- Counter widths:
  - The tick counter is sized by $clog2(TICK_CYCLES).
  - The beep counter is sized by $clog2(BEEP_CYCLES).
  - remain never underflows or wraps below 0.

## Timing
- All outputs are registered.
- Reset values: led=4'b0000, remain=WINDOW, foul=0, timeout=0, beep=0. State is IDLE and all counters are 0.
- Latency from input pulse to output is 1 cycle. A pulse sampled at edge N is visible on led/foul/timeout/state after edge N.
- beep rises on the same edge that led/foul/timeout update. It falls BEEP_CYCLES edges later.
- remain timing: if ARMED is entered at edge S, the first decrement is visible after edge S+TICK_CYCLES and the k-th after edge S+k·TICK_CYCLES.
- TIMEOUT is visible after edge S+WINDOW·TICK_CYCLES.
- Reset or clear asserted mid-countdown or mid-beep takes effect on the next edge, with no residual pulse.

## Test plan
Bench parameters: TICK_CYCLES=10, WINDOW=3, BEEP_CYCLES=5. Clock period 20 ns.
- Reset: hold rst_n low 5 cycles, then release. Required: led=0000, remain=3, beep=0, foul=0, timeout=0, and all stay so with idle inputs.
- Valid answer:
  - Stimulus: start_flag, then key_flag=0100 twelve cycles later.
  - Required: led=0100 one cycle later, remain=2 frozen, beep high exactly 5 cycles.
  - A later key_flag=0001 leaves led unchanged.
- Simultaneous press: in ARMED, key_flag=0110 in one cycle. Required: led=0010.
- Foul:
  - Stimulus: key_flag=1000 in IDLE.
  - Required: foul=1, led=1000, beep 5 cycles.
  - A following start_flag is ignored until clear_flag, after which the block is in IDLE.
- Timeout:
  - Stimulus: start_flag with no presses.
  - Required: remain reads 3, 2, 1 and then 0 at edges S+10, S+20, S+30. timeout=1 at S+30, beep 5 cycles.
  - A key_flag at exactly S+30 instead yields LOCKED with remain=1.
- Abort:
  - clear_flag during the beep in LOCKED: all outputs at IDLE values the next cycle, with beep=0.
  - rst_n low mid-ARMED: same result, and remain returns to 3.
